clint_timer_unit: RTL and testbench

// - Core-local interrupt source: the memory-mapped machine timer (mtime/mtimecmp) and software-interrupt (msip) registers.
// - Drives timer_interrupt and software_interrupt into the CSR file, which reflects them in mip[7]/mip[3].
// - Sits on the data-memory side of the CPU as a word-addressed slave with a req/ack handshake.

---
 rtl/clint_timer_unit.sv | 148 ++++++++++++++
 tb/tb_clint_timer_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clint_timer_unit.sv
// clint_timer_unit
// Core-local interrupt source: memory-mapped machine timer (mtime/mtimecmp)
// and machine software-interrupt (msip) registers, exposed as a word-addressed
// slave with a one-cycle req/ack handshake.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   bus_req/bus_we      access request (one cycle) and write select
//   bus_addr            byte address; [31:16] selects the window, [15:2] the word
//   bus_wdata           full-word write data
//   bus_rdata/bus_ack   registered read data and one-cycle acknowledge
//   timer_interrupt     registered (mtime >= mtimecmp)
//   software_interrupt  msip[0]
//
// Optional feature: define CLINT_PRESCALER_EN to tick mtime once every
// PRESCALE clocks instead of every clock.
module clint_timer_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter logic [15:0] PRESCALE  = 16'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  // Word offsets (byte offset >> 2) inside the 64 KiB window.
  localparam logic [13:0] OFF_MSIP  = 14'h0000;
  localparam logic [13:0] OFF_CMP_L = 14'h1000;
  localparam logic [13:0] OFF_CMP_H = 14'h1001;
  localparam logic [13:0] OFF_MT_L  = 14'h2FFE;
  localparam logic [13:0] OFF_MT_H  = 14'h2FFF;

  logic        msip_q, msip_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tint_q, tint_d;

  logic        hit, wr;
  logic [13:0] woff;
  logic        wr_mt_l, wr_mt_h;
  logic        tick;

  assign hit     = bus_req && (bus_addr[31:16] == BASE_ADDR[31:16]);
  assign wr      = hit && bus_we;
  assign woff    = bus_addr[15:2];
  assign wr_mt_l = wr && (woff == OFF_MT_L);
  assign wr_mt_h = wr && (woff == OFF_MT_H);

`ifdef CLINT_PRESCALER_EN
  // PRESCALE of 0 or 1 both collapse to a tick every clock.
  localparam logic [15:0] PS_LAST = (PRESCALE <= 16'd1) ? 16'd0 : PRESCALE - 16'd1;

  logic [15:0] ps_cnt_q, ps_cnt_d;
  logic        unused_bits;

  assign tick        = (ps_cnt_q == PS_LAST);
  assign unused_bits = ^bus_addr[1:0];

  always_comb begin
    ps_cnt_d = tick ? 16'd0 : ps_cnt_q + 16'd1;
    // Software setting mtime restarts the tick period from the write.
    if (wr_mt_l || wr_mt_h) ps_cnt_d = 16'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ps_cnt_q <= 16'd0;
    else       ps_cnt_q <= ps_cnt_d;
  end
`else
  logic unused_bits;

  assign tick        = 1'b1;
  assign unused_bits = ^{bus_addr[1:0], PRESCALE};
`endif

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    ack_d      = hit;
    rdata_d    = rdata_q;
    // Compare uses current register values, so a write is seen one cycle later.
    tint_d     = (mtime_q >= mtimecmp_q);

    if (wr) begin
      case (woff)
        OFF_MSIP:  msip_d             = bus_wdata[0];
        OFF_CMP_L: mtimecmp_d[31:0]   = bus_wdata;
        OFF_CMP_H: mtimecmp_d[63:32]  = bus_wdata;
        default:   ;
      endcase
    end

    // A write to either half wins over the tick; the other half holds,
    // so no carry propagates on that edge.
    if (wr_mt_l)      mtime_d = {mtime_q[63:32], bus_wdata};
    else if (wr_mt_h) mtime_d = {bus_wdata, mtime_q[31:0]};
    else if (tick)    mtime_d = mtime_q + 64'd1;

    // Reads return pre-edge values; writes and unmapped offsets return 0.
    if (hit) begin
      rdata_d = 32'd0;
      if (!bus_we) begin
        case (woff)
          OFF_MSIP:  rdata_d = {31'd0, msip_q};
          OFF_CMP_L: rdata_d = mtimecmp_q[31:0];
          OFF_CMP_H: rdata_d = mtimecmp_q[63:32];
          OFF_MT_L:  rdata_d = mtime_q[31:0];
          OFF_MT_H:  rdata_d = mtime_q[63:32];
          default:   rdata_d = 32'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msip_q     <= 1'b0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= {64{1'b1}};
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      tint_q     <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      tint_q     <= tint_d;
    end
  end

  assign bus_ack            = ack_q;
  assign bus_rdata          = rdata_q;
  assign timer_interrupt    = tint_q;
  assign software_interrupt = msip_q;

endmodule

// File: tb/tb_clint_timer_unit.sv
// Directed bench for clint_timer_unit. Inputs change and outputs are sampled
// on the falling edge; each bus access occupies exactly one clock, so the
// number of rising edges since the last mtime write fixes every mtime value.
module tb_clint_timer_unit;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] MSIP = BASE + 32'h0000;
  localparam logic [31:0] CMPL = BASE + 32'h4000;
  localparam logic [31:0] CMPH = BASE + 32'h4004;
  localparam logic [31:0] MTL  = BASE + 32'hBFF8;
  localparam logic [31:0] MTH  = BASE + 32'hBFFC;

`ifdef CLINT_PRESCALER_EN
  localparam bit PS = 1'b1;
`else
  localparam bit PS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, timer_interrupt, software_interrupt;

  int n_chk = 0;
  int n_err = 0;

  clint_timer_unit #(.BASE_ADDR(BASE), .PRESCALE(16'd4)) dut (
    .clock              (clock),
    .reset              (reset),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_rdata          (bus_rdata),
    .bus_ack            (bus_ack),
    .timer_interrupt    (timer_interrupt),
    .software_interrupt (software_interrupt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for one clock; returns on the next falling edge with
  // the ack/rdata for that request visible.
  task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    @(negedge clock);
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 32'd0; bus_wdata = 32'd0;
    idle(2);
    check("rst_ack",   {31'd0, bus_ack}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_tint",  {31'd0, timer_interrupt}, 32'd0);
    check("rst_sint",  {31'd0, software_interrupt}, 32'd0);
    reset = 1'b0;

    // Reset register values.
    acc(1'b0, MTL, 32'd0);
    check("mtime_rst_ack", {31'd0, bus_ack}, 32'd1);
    check("mtime_rst",     bus_rdata, 32'd0);
    acc(1'b0, CMPL, 32'd0); check("cmp_lo_rst", bus_rdata, 32'hFFFF_FFFF);
    acc(1'b0, CMPH, 32'd0); check("cmp_hi_rst", bus_rdata, 32'hFFFF_FFFF);
    acc(1'b0, MSIP, 32'd0); check("msip_rst",   bus_rdata, 32'd0);

    // Software interrupt.
    acc(1'b1, MSIP, 32'd1);
    check("msip_w1_ack",   {31'd0, bus_ack}, 32'd1);
    check("msip_w1_rdata", bus_rdata, 32'd0);
    check("sint_set",      {31'd0, software_interrupt}, 32'd1);
    acc(1'b0, MSIP, 32'd0); check("msip_rd1", bus_rdata, 32'd1);
    acc(1'b1, MSIP, 32'd0); check("sint_clr", {31'd0, software_interrupt}, 32'd0);

    // Window decode and unmapped offsets.
    acc(1'b0, CMPL, 32'd0); check("cmp_lo_rd", bus_rdata, 32'hFFFF_FFFF);
    acc(1'b0, 32'h0300_0000, 32'd0);
    check("miss_noack", {31'd0, bus_ack}, 32'd0);
    check("miss_hold",  bus_rdata, 32'hFFFF_FFFF);
    acc(1'b0, BASE + 32'h1000, 32'd0);
    check("unmapped_ack", {31'd0, bus_ack}, 32'd1);
    check("unmapped_rd",  bus_rdata, 32'd0);

    // Timer compare: mtime = 0 at edge A, so mtime == edges since A.
    acc(1'b1, MTL,  32'd0);       // A
    acc(1'b1, CMPH, 32'd0);       // A+1
    acc(1'b1, CMPL, 32'h10);      // A+2
    idle(14);                     // through A+16: mtime reached 0x10 on this edge
    check("tint_before", {31'd0, timer_interrupt}, 32'd0);
    idle(1);                      // A+17
    check("tint_rise", {31'd0, timer_interrupt}, 32'd1);
    acc(1'b0, MTL, 32'd0);        // A+18 reads pre-edge value 17
    check("mtime_run", bus_rdata, 32'h11);
    check("tint_read_noclr", {31'd0, timer_interrupt}, 32'd1);
    acc(1'b1, CMPL, 32'h100);     // A+19
    check("tint_cmp_lat", {31'd0, timer_interrupt}, 32'd1);
    idle(1);
    check("tint_fall", {31'd0, timer_interrupt}, 32'd0);

    // Carry from low into high half.
    acc(1'b1, MTL, 32'hFFFF_FFFF); // B
    acc(1'b0, MTL, 32'd0); check("carry_lo_pre", bus_rdata, 32'hFFFF_FFFF);
    acc(1'b0, MTH, 32'd0); check("carry_hi",     bus_rdata, 32'd1);
    acc(1'b0, MTL, 32'd0); check("carry_lo",     bus_rdata, 32'd1);

    // Writes win over the tick; other half holds.
    acc(1'b1, MTL, 32'h1234_5678);
    acc(1'b0, MTL, 32'd0); check("wr_lo_exact", bus_rdata, 32'h1234_5678);
    acc(1'b0, MTH, 32'd0); check("wr_lo_hi_hold", bus_rdata, 32'd1);
    acc(1'b1, MTH, 32'hAAAA_0000);
    acc(1'b0, MTL, 32'd0); check("wr_hi_lo_hold", bus_rdata, 32'h1234_567A);
    acc(1'b0, MTH, 32'd0); check("wr_hi_exact",   bus_rdata, 32'hAAAA_0000);

    // 64-bit wrap with mtimecmp = 0.
    acc(1'b1, CMPL, 32'd0);
    acc(1'b1, MTL, 32'hFFFF_FFFF);
    acc(1'b1, MTH, 32'hFFFF_FFFF);
    acc(1'b0, MTH, 32'd0);
    check("wrap_pre",   bus_rdata, 32'hFFFF_FFFF);
    check("wrap_tint0", {31'd0, timer_interrupt}, 32'd1);
    acc(1'b0, MTH, 32'd0);
    check("wrap_hi",    bus_rdata, 32'd0);
    check("wrap_tint1", {31'd0, timer_interrupt}, 32'd1);
    acc(1'b0, MTL, 32'd0);
    check("wrap_lo",    bus_rdata, 32'd1);
    check("wrap_tint2", {31'd0, timer_interrupt}, 32'd1);

    // Tick rate (prescale 4 when enabled, else every clock).
    acc(1'b1, MTL, 32'd0);        // P
    idle(3);
    acc(1'b0, MTL, 32'd0); check("rate_p4", bus_rdata, PS ? 32'd0 : 32'd3);
    acc(1'b0, MTL, 32'd0); check("rate_p5", bus_rdata, PS ? 32'd1 : 32'd4);
    idle(2);
    acc(1'b0, MTL, 32'd0); check("rate_p8", bus_rdata, PS ? 32'd1 : 32'd7);
    acc(1'b0, MTL, 32'd0); check("rate_p9", bus_rdata, PS ? 32'd2 : 32'd8);

    // Reset asserted while a read is pending.
    acc(1'b1, MSIP, 32'd1);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = CMPL;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ack",   {31'd0, bus_ack}, 32'd0);
    check("rst_mid_rdata", bus_rdata, 32'd0);
    check("rst_mid_sint",  {31'd0, software_interrupt}, 32'd0);
    check("rst_mid_tint",  {31'd0, timer_interrupt}, 32'd0);
    @(negedge clock);
    bus_req = 1'b0;
    check("rst_mid_noack", {31'd0, bus_ack}, 32'd0);
    reset = 1'b0;
    acc(1'b0, CMPL, 32'd0);
    check("post_rst_ack", {31'd0, bus_ack}, 32'd1);
    check("post_rst_cmp", bus_rdata, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
